// File: rtl/wb_csr_bank.sv
// Wishbone B4 registered-feedback CSR bank: read/write control words, live read-only status
// words, classic/constant/incrementing bursts with wrap modes, and self-clearing pulse bits.
module wb_csr_bank #(
  parameter int unsigned        N_RW       = 8,
  parameter int unsigned        N_RO       = 4,
  parameter int unsigned        ADR_W      = 10,
  parameter logic [N_RW*32-1:0] RESET_VAL  = '0,
  parameter logic [N_RW*32-1:0] PULSE_MASK = '0,
  parameter int unsigned        PULSE_LEN  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [ADR_W+1:0]     adr_i,
  input  logic [31:0]          dat_i,
  input  logic [3:0]           sel_i,
  input  logic [2:0]           cti_i,
  input  logic [1:0]           bte_i,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 rty_o,
  output logic [31:0]          dat_o,
  output logic [N_RW*32-1:0]   ctrl_o,
  input  logic [N_RO*32-1:0]   status_i,
  output logic [N_RW-1:0]      wr_stb_o
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e              state_q, state_d;
  logic [ADR_W-1:0]    bcnt_q, bcnt_d, bcnt_next;
  logic [N_RW*32-1:0]  ctrl_q, ctrl_d;
  logic [N_RW-1:0]     wr_stb_q, wr_stb_d;
  logic [7:0]          cnt_q [N_RW];
  logic [7:0]          cnt_d [N_RW];

  logic [31:0] word_idx;
  logic        req, active, is_ctrl, is_stat, bad_cti, bad, ack, err, commit;
  logic [31:0] byte_mask, rd_ctrl, rd_stat;
  logic        unused_adr;

  assign unused_adr = ^adr_i[1:0];

  // bcnt is at most 32 bits wide, so the zero-extended index covers every word
  assign word_idx  = 32'(bcnt_q);
  assign req       = cyc_i & stb_i;
  assign active    = (state_q == StActive) & ~reset_i;
  assign is_ctrl   = word_idx < N_RW;
  assign is_stat   = ~is_ctrl & (word_idx < N_RW + N_RO);
  assign bad_cti   = (cti_i >= 3'd3) && (cti_i <= 3'd6);
  assign bad       = bad_cti | ~(is_ctrl | is_stat) | (we_i & is_stat);
  assign ack       = active & req & ~bad;
  assign err       = active & req & bad;
  assign commit    = ack & we_i & is_ctrl;
  assign byte_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

  assign ack_o    = ack;
  assign err_o    = err;
  assign rty_o    = 1'b0;
  assign ctrl_o   = ctrl_q;
  assign wr_stb_o = wr_stb_q;

  always_comb begin
    rd_ctrl = '0;
    rd_stat = '0;
    for (int k = 0; k < N_RW; k++) begin
      if (word_idx == 32'(k)) rd_ctrl = ctrl_q[k*32 +: 32];
    end
    for (int k = 0; k < N_RO; k++) begin
      if (word_idx == 32'(N_RW + k)) rd_stat = status_i[k*32 +: 32];
    end
    dat_o = '0;
    if (ack) dat_o = is_ctrl ? rd_ctrl : rd_stat;
  end

  // Wrapping modes only advance the low bits; the upper bits stay on the same block.
  always_comb begin
    bcnt_next = bcnt_q;
    case (bte_i)
      2'b00:   bcnt_next = bcnt_q + 1'b1;
      2'b01:   bcnt_next = {bcnt_q[ADR_W-1:2], bcnt_q[1:0] + 2'd1};
      2'b10:   bcnt_next = {bcnt_q[ADR_W-1:3], bcnt_q[2:0] + 3'd1};
      default: bcnt_next = {bcnt_q[ADR_W-1:4], bcnt_q[3:0] + 4'd1};
    endcase
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          bcnt_d  = adr_i[ADR_W+1:2];
          state_d = StActive;
        end
      end
      StActive: begin
        if (!cyc_i || err) begin
          state_d = StIdle;
        end else if (ack) begin
          case (cti_i)
            3'b001:  state_d = StActive;
            3'b010:  bcnt_d = bcnt_next;
            default: state_d = StIdle;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    wr_stb_d = '0;
    for (int k = 0; k < N_RW; k++) begin
      logic [31:0] reg_v;
      logic [31:0] pmask;
      logic [31:0] wmask;
      reg_v    = ctrl_q[k*32 +: 32];
      pmask    = PULSE_MASK[k*32 +: 32];
      wmask    = pmask & byte_mask;
      cnt_d[k] = cnt_q[k];
      if (cnt_q[k] != 8'd0) begin
        cnt_d[k] = cnt_q[k] - 8'd1;
        if (cnt_q[k] == 8'd1) reg_v = reg_v & ~pmask;
      end
      // A same-cycle write takes precedence over counter expiry.
      if (commit && (word_idx == 32'(k))) begin
        wr_stb_d[k] = 1'b1;
        reg_v       = (reg_v & ~byte_mask) | (dat_i & byte_mask);
        if ((dat_i & wmask) != '0) begin
          cnt_d[k] = 8'(PULSE_LEN);
        end else if (wmask != '0) begin
          cnt_d[k] = 8'd0;
        end
      end
      ctrl_d[k*32 +: 32] = reg_v;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      bcnt_q   <= '0;
      ctrl_q   <= RESET_VAL;
      wr_stb_q <= '0;
      for (int k = 0; k < N_RW; k++) cnt_q[k] <= 8'd0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      ctrl_q   <= ctrl_d;
      wr_stb_q <= wr_stb_d;
      for (int k = 0; k < N_RW; k++) cnt_q[k] <= cnt_d[k];
    end
  end

endmodule

// File: tb/tb_wb_csr_bank.sv
// Scoreboard bench for wb_csr_bank: expected responses are queued as beats are driven and
// popped when the slave acknowledges or errors.
module tb_wb_csr_bank;

  localparam logic [255:0] RV = {32'hCAFE_0007, 32'h0, 32'h0000_5A5A, 160'h0};
  localparam logic [255:0] PM = {32'h0, 32'h1, 192'h0};
  localparam int PB = 6 * 32;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;

  logic         clk, rst, cyc, stb, we;
  logic [11:0]  adr;
  logic [31:0]  wdat;
  logic [3:0]   sel;
  logic [2:0]   cti;
  logic [1:0]   bte;
  logic         ack_o, err_o, rty_o;
  logic [31:0]  dat_o;
  logic [255:0] ctrl_o;
  logic [127:0] status;
  logic [7:0]   wr_stb_o;

  logic [31:0]  mdl [8];
  exp_t         exp_q [$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           hi_total = 0;
  int           snap;

  wb_csr_bank #(
    .N_RW      (8),
    .N_RO      (4),
    .ADR_W     (10),
    .RESET_VAL (RV),
    .PULSE_MASK(PM),
    .PULSE_LEN (8)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .cyc_i   (cyc),
    .stb_i   (stb),
    .we_i    (we),
    .adr_i   (adr),
    .dat_i   (wdat),
    .sel_i   (sel),
    .cti_i   (cti),
    .bte_i   (bte),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .rty_o   (rty_o),
    .dat_o   (dat_o),
    .ctrl_o  (ctrl_o),
    .status_i(status),
    .wr_stb_o(wr_stb_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (ctrl_o[PB]) hi_total <= hi_total + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    logic [255:0] rv_v;
    rv_v = RV;
    for (int k = 0; k < 8; k++) mdl[k] = rv_v[k*32 +: 32];
  endtask

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
    for (int j = 0; j < 4; j++) if (s[j]) mdl[a][j*8 +: 8] = d[j*8 +: 8];
  endtask

  task automatic check_ctrl(input string tag);
    for (int k = 0; k < 8; k++) check_eq(tag, ctrl_o[k*32 +: 32], mdl[k]);
  endtask

  // Status word a (8..11) is driven with the value a.
  function automatic logic [31:0] read_model(input int a);
    return (a < 8) ? mdl[a] : 32'(a);
  endfunction

  function automatic logic bad_beat(input logic w, input int a, input logic [2:0] c);
    return (c >= 3'd3 && c <= 3'd6) || a >= 12 || (w && a >= 8);
  endfunction

  function automatic int next_addr(input int a, input logic [1:0] bt, input logic [2:0] c);
    int m;
    if (c == 3'b001) return a;
    if (bt == 2'b00) return (a + 1) % 1024;
    m = (bt == 2'b01) ? 3 : (bt == 2'b10) ? 7 : 15;
    return (a & ~m) | ((a + 1) & m);
  endfunction

  task automatic drive_beat(input logic w, input int a, input int beat, input int nbeats,
                            input logic [2:0] cti_b, input logic [2:0] cti_last,
                            input logic [31:0] wbase, input logic push);
    exp_t e;
    cti  = (beat == nbeats - 1) ? cti_last : cti_b;
    wdat = wbase + 32'(beat);
    if (push) begin
      e.is_err = bad_beat(w, a, cti);
      e.data   = e.is_err ? 32'h0 : read_model(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic wb_xfer(input logic w, input int start, input int nbeats,
                         input logic [2:0] cti_b, input logic [2:0] cti_last,
                         input logic [1:0] bt, input logic [3:0] sl, input logic [31:0] wbase,
                         input int stall_at, input int reset_at);
    int a;
    int beat;
    int guard;
    logic fin, adv, aborted;
    logic [7:0] stb_exp;
    exp_t e;
    a = start; beat = 0; guard = 0; fin = 1'b0; aborted = 1'b0; stb_exp = '0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = sl; bte = bt;
    adr = 12'(start * 4);
    drive_beat(w, a, beat, nbeats, cti_b, cti_last, wbase, 1'b1);
    while (!fin) begin
      adv = 1'b0;
      @(negedge clk);
      check_eq("wr_stb", 32'(wr_stb_o), 32'(stb_exp));
      stb_exp = '0;
      if (ack_o || err_o) begin
        e = exp_q.pop_front();
        check_eq("err_resp", 32'(err_o), 32'(e.is_err));
        check_eq("ack_resp", 32'(ack_o), 32'(!e.is_err));
        check_eq("rdata", dat_o, e.data);
        if (ack_o && w && a < 8) begin
          model_write(a, wdat, sl);
          stb_exp[3'(a)] = 1'b1;
        end
        beat++;
        guard = 0;
        if (err_o || beat == nbeats) fin = 1'b1;
        else begin
          a   = next_addr(a, bt, cti_b);
          adv = 1'b1;
        end
      end else begin
        guard++;
        if (guard > 8) begin
          check_eq("xfer_timeout", 32'(ack_o | err_o), 32'd1);
          fin = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (adv) begin
        if (beat == stall_at) begin
          stb = 1'b0;
          repeat (2) begin
            @(negedge clk);
            check_eq("stall_wr_stb", 32'(wr_stb_o), 32'(stb_exp));
            stb_exp = '0;
            check_eq("stall_ack", 32'(ack_o | err_o), 32'd0);
            @(posedge clk); #1;
          end
          stb = 1'b1;
        end
        if (beat == reset_at) begin
          rst = 1'b1;
          drive_beat(w, a, beat, nbeats, cti_b, cti_last, wbase, 1'b0);
          @(negedge clk);
          check_eq("rst_cycle_ack", 32'(ack_o), 32'd0);
          @(posedge clk); #1;
          rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
          @(negedge clk);
          check_eq("post_rst_ack", 32'(ack_o), 32'd0);
          check_eq("post_rst_wr_stb", 32'(wr_stb_o), 32'd0);
          model_reset();
          check_ctrl("post_rst_ctrl");
          fin = 1'b1;
          aborted = 1'b1;
        end else begin
          drive_beat(w, a, beat, nbeats, cti_b, cti_last, wbase, 1'b1);
        end
      end
    end
    if (!aborted) begin
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      check_eq("end_wr_stb", 32'(wr_stb_o), 32'(stb_exp));
      check_eq("end_ack", 32'(ack_o), 32'd0);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    sel = '0; cti = '0; bte = '0;
    status = {32'hB, 32'hA, 32'h9, 32'h8};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ack", 32'(ack_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_rty", 32'(rty_o), 32'd0);
    check_eq("rst_wr_stb", 32'(wr_stb_o), 32'd0);
    check_eq("rst_dat", dat_o, 32'd0);
    check_ctrl("rst_ctrl");
    step(1);
    rst = 1'b0;
    step(1);

    // Single write with partial byte selects, then single read ended with cti 000
    wb_xfer(1'b1, 2, 1, 3'b000, 3'b111, 2'b00, 4'b0011, 32'hA5A5_1234, -1, -1);
    wb_xfer(1'b0, 2, 1, 3'b000, 3'b000, 2'b00, 4'hF, 32'h0, -1, -1);
    check_eq("word2_model", ctrl_o[2*32 +: 32], 32'h0000_1234);
    step(1);

    // Linear write and read bursts, each with a two-cycle wait state
    wb_xfer(1'b1, 0, 5, 3'b010, 3'b111, 2'b00, 4'hF, 32'h1000_0000, 2, -1);
    step(1);
    wb_xfer(1'b0, 0, 5, 3'b010, 3'b111, 2'b00, 4'hF, 32'h0, 3, -1);
    step(1);

    // Wrap-4 over status, wrap-8 over control, wrap-16 running into an illegal word
    wb_xfer(1'b0, 10, 4, 3'b010, 3'b111, 2'b01, 4'hF, 32'h0, -1, -1);
    step(1);
    wb_xfer(1'b0, 5, 5, 3'b010, 3'b111, 2'b10, 4'hF, 32'h0, -1, -1);
    step(1);
    wb_xfer(1'b0, 9, 6, 3'b010, 3'b111, 2'b11, 4'hF, 32'h0, -1, -1);
    step(1);

    // Error cases
    wb_xfer(1'b0, 12, 1, 3'b000, 3'b111, 2'b00, 4'hF, 32'h0, -1, -1);
    step(1);
    wb_xfer(1'b1, 9, 1, 3'b000, 3'b111, 2'b00, 4'hF, 32'h9999_9999, -1, -1);
    check_ctrl("err_write_ctrl");
    step(1);
    wb_xfer(1'b0, 3, 1, 3'b000, 3'b011, 2'b00, 4'hF, 32'h0, -1, -1);
    step(1);
    wb_xfer(1'b1, 7, 2, 3'b010, 3'b111, 2'b00, 4'hF, 32'h7700_0000, -1, -1);
    check_ctrl("mid_burst_err_ctrl");
    step(1);

    // Constant-address burst and a zero-select write
    wb_xfer(1'b1, 4, 3, 3'b001, 3'b111, 2'b00, 4'hF, 32'h4440_0000, -1, -1);
    wb_xfer(1'b0, 4, 1, 3'b000, 3'b111, 2'b00, 4'hF, 32'h0, -1, -1);
    wb_xfer(1'b1, 3, 1, 3'b000, 3'b111, 2'b00, 4'h0, 32'hFFFF_FFFF, -1, -1);
    check_ctrl("sel0_ctrl");
    step(1);

    // Pulse: plain, retriggered five cycles later, and cleared three cycles later
    snap = hi_total;
    wb_xfer(1'b1, 6, 1, 3'b000, 3'b111, 2'b00, 4'b0001, 32'h1, -1, -1);
    step(20);
    check_eq("pulse_len", 32'(hi_total - snap), 32'd8);
    mdl[6] = 32'h0;
    check_ctrl("pulse_expired");
    snap = hi_total;
    wb_xfer(1'b1, 6, 1, 3'b000, 3'b111, 2'b00, 4'b0001, 32'h1, -1, -1);
    step(3);
    wb_xfer(1'b1, 6, 1, 3'b000, 3'b111, 2'b00, 4'b0001, 32'h1, -1, -1);
    step(20);
    check_eq("pulse_retrigger", 32'(hi_total - snap), 32'd13);
    mdl[6] = 32'h0;
    snap = hi_total;
    wb_xfer(1'b1, 6, 1, 3'b000, 3'b111, 2'b00, 4'b0001, 32'h1, -1, -1);
    step(1);
    wb_xfer(1'b1, 6, 1, 3'b000, 3'b111, 2'b00, 4'b0001, 32'h0, -1, -1);
    check_eq("pulse_clear", 32'(hi_total - snap), 32'd3);
    step(12);
    check_eq("pulse_stays_clear", 32'(hi_total - snap), 32'd3);
    wb_xfer(1'b0, 6, 1, 3'b000, 3'b111, 2'b00, 4'hF, 32'h0, -1, -1);
    step(1);

    // Reset asserted on beat 3 of a linear write burst
    wb_xfer(1'b1, 0, 6, 3'b010, 3'b111, 2'b00, 4'hF, 32'hDEAD_0000, -1, 3);
    step(1);
    wb_xfer(1'b0, 7, 1, 3'b000, 3'b111, 2'b00, 4'hF, 32'h0, -1, -1);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
